// File: rtl/dbus_router.sv
// Data-bus router: decodes one master onto SLAVE_CNT address windows, tracks the
// transaction with a WAIT/HOLD/ERR FSM and reports unmapped, timeout and protocol faults.
module dbus_router #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned BUS_ACC_CNT = 3,
    parameter int unsigned SLAVE_CNT   = 6,
    // Defaults follow the femto memory map: ROM, TCM, SRAM, NOR, QSPI, BRIDGE (index 0..5).
    parameter logic [SLAVE_CNT*XLEN-1:0] SLAVE_BASE = {
        32'h8000_0000, 32'h4000_0000, 32'h3000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    },
    parameter logic [SLAVE_CNT*8-1:0] SLAVE_SPAN = {
        8'd28, 8'd24, 8'd24, 8'd20, 8'd16, 8'd16
    },
    parameter int unsigned TIMEOUT     = 255,
    localparam int unsigned ACC_W = (BUS_ACC_CNT > 1) ? $clog2(BUS_ACC_CNT) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,

    input  logic                           m_req,
    input  logic [XLEN-1:0]                m_addr,
    input  logic                           m_w_rb,
    input  logic [ACC_W-1:0]               m_acc,
    input  logic [BUS_WIDTH-1:0]           m_wdata,
    output logic                           m_resp,
    output logic [BUS_WIDTH-1:0]           m_rdata,

    output logic [SLAVE_CNT-1:0]           s_req,
    output logic [XLEN-1:0]                s_addr,
    output logic                           s_w_rb,
    output logic [ACC_W-1:0]               s_acc,
    output logic [BUS_WIDTH-1:0]           s_wdata,
    input  logic [SLAVE_CNT-1:0]           s_resp,
    input  logic [SLAVE_CNT*BUS_WIDTH-1:0] s_rdata,

    output logic                           bus_fault,
    output logic [XLEN-1:0]                bus_fault_addr,
    output logic [1:0]                     bus_fault_code,
    input  logic                           bus_halt
);

    localparam int unsigned IDX_W = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] CodeUnmapped = 2'b01;
    localparam logic [1:0] CodeTimeout  = 2'b10;
    localparam logic [1:0] CodeProtocol = 2'b11;

    typedef enum logic [1:0] {StIdle, StWait, StHold, StErr} state_e;

    state_e                 state_q;
    logic [IDX_W-1:0]       sel_q;
    logic [XLEN-1:0]        addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BUS_WIDTH-1:0]   hold_q;
    logic [BUS_WIDTH-1:0]   rdata_q;
    logic [1:0]             err_code_q;
    logic                   proto_q;
    logic                   proto_pend_q;

    logic [SLAVE_CNT-1:0]   hit;
    logic                   any_hit;
    logic [IDX_W-1:0]       sel_idx;
    logic [SLAVE_CNT-1:0]   req_vec;
    logic                   new_resp;
    logic [BUS_WIDTH-1:0]   new_rdata;
    logic                   cur_resp;
    logic [BUS_WIDTH-1:0]   cur_rdata;
    logic                   idle;
    logic                   viol;
    logic                   done;
    logic [BUS_WIDTH-1:0]   dlv_data;
    logic                   err_out;
    logic                   timeout_hit;

    assign s_addr  = m_addr;
    assign s_w_rb  = m_w_rb;
    assign s_acc   = m_acc;
    assign s_wdata = m_wdata;

    // Window masks are elaboration constants; a span of XLEN or more matches everything.
    for (genvar g = 0; g < int'(SLAVE_CNT); g++) begin : g_dec
        localparam int unsigned      SPAN = 32'(SLAVE_SPAN[g*8 +: 8]);
        localparam logic [XLEN-1:0] BASE = SLAVE_BASE[g*XLEN +: XLEN];
        localparam logic [XLEN-1:0] MASK =
            (SPAN >= XLEN) ? '0 : ~((XLEN'(1) << SPAN) - XLEN'(1));
        assign hit[g] = ((m_addr & MASK) == BASE);
    end

    // Scanning downwards leaves the lowest matching index selected.
    always_comb begin
        any_hit = 1'b0;
        sel_idx = '0;
        for (int i = int'(SLAVE_CNT) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        req_vec   = '0;
        new_resp  = 1'b0;
        new_rdata = '0;
        cur_resp  = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < int'(SLAVE_CNT); i++) begin
            if (IDX_W'(i) == sel_idx) begin
                req_vec[i] = 1'b1;
                new_resp   = s_resp[i];
                new_rdata  = s_rdata[i*BUS_WIDTH +: BUS_WIDTH];
            end
            if (IDX_W'(i) == sel_q) begin
                cur_resp  = s_resp[i];
                cur_rdata = s_rdata[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign idle        = (state_q == StIdle);
    assign viol        = m_req & ~idle;
    assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    always_comb begin
        done     = 1'b0;
        dlv_data = '0;
        unique case (state_q)
            StIdle: begin
                done     = m_req & any_hit & new_resp & ~bus_halt;
                dlv_data = new_rdata;
            end
            StWait: begin
                done     = cur_resp & ~bus_halt;
                dlv_data = cur_rdata;
            end
            StHold: begin
                done     = ~bus_halt;
                dlv_data = hold_q;
            end
            StErr: begin
                done     = ~bus_halt;
                dlv_data = '0;
            end
        endcase
    end

    // Combinational outputs are gated by rstn so they stay quiet while reset is held.
    assign s_req   = (rstn && m_req && idle && any_hit) ? req_vec : '0;
    assign m_resp  = rstn & done;
    assign m_rdata = m_resp ? dlv_data : rdata_q;

    assign err_out        = (state_q == StErr) & ~bus_halt;
    assign bus_fault      = rstn & (err_out | proto_pend_q);
    assign bus_fault_addr = bus_fault ? addr_q : '0;
    assign bus_fault_code = !bus_fault ? 2'b00 :
                            (err_out && !(proto_q || viol)) ? err_code_q : CodeProtocol;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            rdata_q      <= '0;
            err_code_q   <= 2'b00;
            proto_q      <= 1'b0;
            proto_pend_q <= 1'b0;
        end else begin
            proto_pend_q <= 1'b0;
            if (viol) begin
                proto_q <= 1'b1;
            end
            if (done) begin
                rdata_q <= dlv_data;
            end
            unique case (state_q)
                StIdle: begin
                    if (m_req) begin
                        addr_q <= m_addr;
                        if (any_hit) begin
                            sel_q <= sel_idx;
                            if (new_resp) begin
                                if (bus_halt) begin
                                    hold_q  <= new_rdata;
                                    state_q <= StHold;
                                end
                            end else begin
                                cnt_q   <= '0;
                                state_q <= StWait;
                            end
                        end else begin
                            err_code_q <= CodeUnmapped;
                            state_q    <= StErr;
                        end
                    end
                end
                StWait: begin
                    if (cur_resp) begin
                        if (bus_halt) begin
                            hold_q  <= cur_rdata;
                            state_q <= StHold;
                        end else begin
                            state_q <= StIdle;
                            if (proto_q || viol) begin
                                proto_pend_q <= 1'b1;
                                proto_q      <= 1'b0;
                            end
                        end
                    end else if (timeout_hit) begin
                        err_code_q <= CodeTimeout;
                        state_q    <= StErr;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (!bus_halt) begin
                        state_q <= StIdle;
                        if (proto_q || viol) begin
                            proto_pend_q <= 1'b1;
                            proto_q      <= 1'b0;
                        end
                    end
                end
                StErr: begin
                    // The protocol code is reported here, so no standalone pulse follows.
                    if (!bus_halt) begin
                        state_q <= StIdle;
                        proto_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/dbus_router.md
DBUS_ROUTER -- requirements
Module: dbus_router

Interface
REQ-001 SHALL have parameter SLAVE_CNT, default 6: number of slave ports, legal range 1..16.
REQ-002 SHALL have parameter SLAVE_BASE, default {BRIDGE_BASE,QSPI_BASE,NOR_BASE,SRAM_BASE,TCM_BASE,ROM_BASE} from femto.vh: packed SLAVE_CNT*XLEN, with slave i in bits [i*XLEN +: XLEN].
REQ-003 SHALL have parameter SLAVE_SPAN, default clog2 of each matching *_SIZE: packed SLAVE_CNT*8, with the log2 window size of slave i in bits [i*8 +: 8].
REQ-004 SHALL have parameter TIMEOUT, default 255: WAIT-cycle limit, where 0 disables the timeout; counter width is clog2(TIMEOUT+1).
REQ-005 SHALL have ports clk (in, 1, clock) and rstn (in, 1, reset); one clock, and reset is asynchronous and active-low.
REQ-006 SHALL have master ports: m_req in 1; m_addr in XLEN; m_w_rb in 1; m_acc in clog2(BUS_ACC_CNT); m_wdata in BUS_WIDTH; m_resp out 1; m_rdata out BUS_WIDTH.
REQ-007 SHALL have slave ports: s_req out SLAVE_CNT; s_addr out XLEN; s_w_rb out 1; s_acc out clog2(BUS_ACC_CNT); s_wdata out BUS_WIDTH; s_resp in SLAVE_CNT; s_rdata in SLAVE_CNT*BUS_WIDTH.
REQ-008 SHALL have fault/control ports: bus_fault out 1 (single-cycle pulse); bus_fault_addr out XLEN; bus_fault_code out 2 (01 unmapped, 10 timeout, 11 protocol); bus_halt in 1.

Function
REQ-009 SHALL decode slave i as hit when (m_addr & ~((1<<SPAN_i)-1)) == BASE_i; on multiple hits, the lowest index wins.
REQ-010 SHALL broadcast s_addr, s_w_rb, s_acc and s_wdata combinationally from the master inputs.
REQ-011 SHALL assert s_req[i] = m_req & hit_i & (state==IDLE) combinationally, giving zero added request latency.
REQ-012 SHALL implement the states IDLE, WAIT, HOLD and ERR, and SHALL latch the selected index and m_addr on the cycle a request is accepted in IDLE.
REQ-013 SHALL, in IDLE with m_req and a hit, complete the transaction in the same cycle if the selected s_resp is high and bus_halt is low; stay in IDLE if it completes; go to HOLD if s_resp is high and bus_halt is high; otherwise go to WAIT.
REQ-014 SHALL, in IDLE with m_req and no hit, issue no s_req, record code 01 and go to ERR.
REQ-015 SHALL, in WAIT, ignore s_resp from non-selected slaves; on the selected s_resp, complete if bus_halt is low (then go to IDLE), otherwise capture s_rdata and go to HOLD.
REQ-016 SHALL increment the timeout counter in WAIT; when TIMEOUT≠0 and the counter reaches TIMEOUT without a response, go to ERR with code 10; the counter SHALL clear on entering WAIT.
REQ-017 SHALL, in HOLD, assert m_resp with the captured data on the first cycle bus_halt is low, then go to IDLE.
REQ-018 SHALL, in ERR with bus_halt low, assert m_resp with m_rdata=0, pulse bus_fault, and drive bus_fault_addr and bus_fault_code from the latched values, then go to IDLE; with bus_halt high it SHALL stay in ERR.
REQ-019 SHALL treat m_req in WAIT, HOLD or ERR as a protocol violation: no s_req is issued, the transaction in flight continues, and a sticky flag sets code 11 on the next ERR or raises a standalone 11 pulse when returning to IDLE.
REQ-020 SHALL assert m_resp for exactly one cycle per accepted request and never while bus_halt is high.
REQ-021 SHALL register m_rdata: on completion it equals the delivered data (slave data, held data or 0), and it holds its last value otherwise.
REQ-022 SHALL ignore a late response from the selected slave arriving after a timeout.

Reset
REQ-023 SHALL, while rstn is low, force state=IDLE, counter=0, m_rdata=0, bus_fault=0, bus_fault_addr=0, bus_fault_code=00, selected index=0 and the sticky flag=0; m_resp and s_req SHALL be 0.
REQ-024 SHALL abandon any transaction in flight on reset without asserting m_resp, and SHALL accept a new request on the first cycle after rstn is released.

Verification
REQ-025 SHALL verify: read to SRAM_BASE+4, SRAM s_resp 2 cycles later with 0xA5A5A5A5 -> only s_req[2] pulses once; m_resp one cycle; m_rdata=0xA5A5A5A5.
REQ-026 SHALL verify: read to an unmapped address 0xF0000000 -> no s_req; next cycle m_resp=1, m_rdata=0, bus_fault pulse, addr=0xF0000000, code=01.
REQ-027 SHALL verify: TIMEOUT=4, NOR never responds -> ERR after 4 WAIT cycles with code 10; a late s_resp is ignored.
REQ-028 SHALL verify: TCM responds with 0x12345678 while bus_halt=1 for 3 cycles -> no m_resp during the halt; m_resp with 0x12345678 on the first unhalted cycle.
REQ-029 SHALL verify: a second m_req in WAIT -> no s_req; the first completes normally; then code 11 pulses.
REQ-030 SHALL verify: rstn dropped in WAIT -> all outputs return to reset values asynchronously; a request after release routes normally.
